// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Fixed-latency 16-bit data memory responder with a valid/ready
//            request port and a held response port.
//            Optional macro MEM_ALIGN_CHECK_EN flags odd byte addresses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int         C_WORDS  = 1 << DEPTH_LOG2;
   localparam logic [3:0] C_LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_next;
   logic                  r_we;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic                  r_lsb;
   logic [15:0]           r_wdata;
   logic [15:0]           r_rdata;
   logic                  r_err;
   logic [15:0]           r_mem [C_WORDS];

   logic                  w_accept;
   logic                  w_enter_resp;
   logic                  w_we;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_lsb;
   logic [15:0]           w_wdata;
   logic                  w_misalign;
   logic                  w_do_write;
   logic                  w_unused;

   assign w_accept = req_valid && req_ready;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_next = RESP;
               end else begin
                  w_next     = WAIT;
                  w_cnt_next = C_LAT_M1;
               end
            end
         end
         WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_next = RESP;
         end
         RESP: begin
            if (resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // With LATENCY==1 the access happens on the acceptance edge itself, so the
   // live request fields are used instead of the not-yet-latched copies.
   assign w_enter_resp = (r_state != RESP) && (w_next == RESP);
   assign w_we    = (r_state == IDLE) ? req_we                  : r_we;
   assign w_idx   = (r_state == IDLE) ? req_addr[DEPTH_LOG2:1]  : r_idx;
   assign w_lsb   = (r_state == IDLE) ? req_addr[0]             : r_lsb;
   assign w_wdata = (r_state == IDLE) ? req_wdata               : r_wdata;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign = w_lsb;
`else
   assign w_misalign = 1'b0;
`endif

   assign w_do_write = w_enter_resp && w_we && !w_misalign && !rst;
   assign w_unused   = &{1'b0, req_addr[15:DEPTH_LOG2+1], w_lsb};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_lsb   <= 1'b0;
         r_wdata <= 16'h0000;
         r_rdata <= 16'h0000;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_we    <= req_we;
            r_idx   <= req_addr[DEPTH_LOG2:1];
            r_lsb   <= req_addr[0];
            r_wdata <= req_wdata;
         end
         if (w_enter_resp) begin
            r_rdata <= (w_we || w_misalign) ? 16'h0000 : r_mem[w_idx];
            r_err   <= w_misalign;
         end else if (r_state == RESP && resp_ready) begin
            r_rdata <= 16'h0000;
            r_err   <= 1'b0;
         end
      end
   end

   // Array contents survive reset; only the write strobe is reset-gated.
   always_ff @(posedge clk) begin
      if (w_do_write) r_mem[w_idx] <= w_wdata;
   end

   assign req_ready  = (r_state == IDLE) && !rst;
   assign busy       = (r_state != IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Table-driven bench with response scoreboard for data_mem_responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          hold;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[11];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int hs_cyc = -100;
   int acc_gap = 0;
   int n_acc = 0;
   int n_resp = 0;
   logic        pend = 1'b0;
   logic [15:0] prev_rd = 16'h0000;
   logic        prev_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Monitor samples at the falling edge, where every signal is settled.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (req_valid && req_ready) begin
            n_acc++;
            acc_cyc = cyc;
            acc_gap = cyc - hs_cyc;
         end
         if (!resp_valid) begin
            check("idle_outputs", {15'd0, resp_rdata, resp_err}, 32'd0);
         end else begin
            if (!pend) begin
               check("latency", cyc - acc_cyc, LAT);
            end else begin
               check("hold_rdata", resp_rdata, prev_rd);
               check("hold_err", resp_err, prev_err);
               check("hold_req_ready", req_ready, 1'b0);
               check("hold_busy", busy, 1'b1);
            end
            if (resp_ready) begin
               n_resp++;
               hs_cyc = cyc;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: got rdata %h expected no response", resp_rdata);
               end else begin
                  e = sb.pop_front();
                  check("resp_rdata", resp_rdata, e.rdata);
                  check("resp_err", resp_err, e.err);
               end
            end
         end
         pend     = resp_valid && !resp_ready;
         prev_rd  = resp_rdata;
         prev_err = resp_err;
      end
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic wait_ready(input string name);
      int t = 0;
      while (!req_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!req_ready) fail_timeout(name);
   endtask

   task automatic wait_resp(input string name, output logic ok);
      int t = 0;
      while (!resp_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      ok = resp_valid;
      if (!ok) begin
         fail_timeout(name);
         sb.delete();
      end
   endtask

   task automatic do_req(input vec_t v);
      logic ok;
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      sb.push_back('{v.exp_rdata, v.exp_err});
      wait_ready("accept");
      @(posedge clk); #1;
      // Scramble request inputs to prove they were latched.
      req_valid = 1'b0;
      req_we    = ~v.we;
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      wait_resp("resp_wait", ok);
      if (ok) begin
         repeat (v.hold) begin
            @(posedge clk); #1;
         end
         resp_ready = 1'b1;
         @(posedge clk); #1;
         resp_ready = 1'b0;
      end
   endtask

   initial begin
      int   r0;
      int   a0;
      int   t;
      logic ok;

      tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 0, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, 1'b0};
      tbl[2]  = '{1'b1, 16'h0202, 16'h1234, 0, 16'h0000, 1'b0};
      tbl[3]  = '{1'b0, 16'h0002, 16'h0000, 2, 16'h1234, 1'b0};
      tbl[4]  = '{1'b1, 16'h0020, 16'h1111, 0, 16'h0000, 1'b0};
      tbl[5]  = '{1'b0, 16'h0020, 16'h0000, 5, 16'h1111, 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
      tbl[6]  = '{1'b1, 16'h0011, 16'hAAAA, 0, 16'h0000, 1'b1};
      tbl[7]  = '{1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1'b0};
      tbl[8]  = '{1'b0, 16'h0011, 16'h0000, 0, 16'h0000, 1'b1};
`else
      tbl[6]  = '{1'b1, 16'h0011, 16'hAAAA, 0, 16'h0000, 1'b0};
      tbl[7]  = '{1'b0, 16'h0010, 16'h0000, 0, 16'hAAAA, 1'b0};
      tbl[8]  = '{1'b0, 16'h0011, 16'h0000, 0, 16'hAAAA, 1'b0};
`endif
      tbl[9]  = '{1'b1, 16'h01FE, 16'h7E57, 0, 16'h0000, 1'b0};
      tbl[10] = '{1'b0, 16'hFFFE, 16'h0000, 1, 16'h7E57, 1'b0};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 16'h0000;
      req_wdata  = 16'h0000;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_rdata", resp_rdata, 16'h0000);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) do_req(tbl[i]);

      // Reset during WAIT must abort a store without writing it.
      r0        = n_resp;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = 16'h5555;
      wait_ready("abort_accept");
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      check("abort_no_resp", n_resp - r0, 0);
      check("abort_busy", busy, 1'b0);
      do_req('{1'b0, 16'h0020, 16'h0000, 0, 16'h1111, 1'b0});

      // req_valid held across the response handshake.
      r0        = n_resp;
      a0        = n_acc;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'h0002;
      sb.push_back('{16'h1234, 1'b0});
      wait_ready("b2b_accept_a");
      @(posedge clk); #1;
      req_addr = 16'h0020;
      sb.push_back('{16'h1111, 1'b0});
      wait_resp("b2b_resp_a", ok);
      resp_ready = 1'b1;
      t = 0;
      while (n_acc < a0 + 2 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      req_valid = 1'b0;
      check("b2b_accept_gap", acc_gap, 1);
      t = 0;
      while (n_resp < r0 + 2 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      resp_ready = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      check("b2b_accepts", n_acc - a0, 2);
      check("b2b_responses", n_resp - r0, 2);
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL take parameter DEPTH_LOG2, default 8, giving the log2 of the word count of the internal 16-bit data array.
REQ-002 The block SHALL take parameter LATENCY, default 3, giving the cycles from request acceptance to response valid (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  load/store request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  16  byte address, already base+offset computed and halfword-aligned by the issuing stage.
REQ-009 req_wdata  input  16  store data.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  consumer accepts the response.
REQ-012 resp_rdata  output  16  load data; 0x0000 for store acknowledgements.
REQ-013 resp_err  output  1  misaligned-access flag (see Configuration).
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be high only in IDLE; a request SHALL be accepted on a cycle where req_valid and req_ready are both high.
REQ-017 On acceptance, the block SHALL latch req_we, req_addr and req_wdata; later changes on the request inputs SHALL have no effect.
REQ-018 On acceptance, the block SHALL enter WAIT with its latency counter at LATENCY-1; if LATENCY is 1, it SHALL go directly to RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on the cycle it reads 1, the next state SHALL be RESP.
REQ-020 The array access SHALL occur on the edge that enters RESP, so resp_valid is first high exactly LATENCY cycles after the acceptance edge.
REQ-021 The word index SHALL be req_addr[DEPTH_LOG2:1]; upper address bits SHALL be ignored, so addresses wrap modulo 2^(DEPTH_LOG2+1) bytes.
REQ-022 A store SHALL write the latched wdata to the indexed word and SHALL return resp_rdata = 0x0000.
REQ-023 A load SHALL return the indexed word in resp_rdata.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_ready is sampled high; the block SHALL then return to IDLE on that edge.
REQ-025 A req_valid that arrives in the same cycle as the response handshake SHALL NOT be accepted; it SHALL be accepted no earlier than the following cycle.
REQ-026 When not in RESP, resp_valid SHALL be 0, resp_rdata SHALL be 0x0000 and resp_err SHALL be 0.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL go to IDLE, clear the counter and drive resp_valid=0, resp_rdata=0x0000, resp_err=0, busy=0 and req_ready=0; req_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-028 Reset asserted while in WAIT SHALL abort the operation, and a pending store SHALL NOT be written.
REQ-029 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With macro MEM_ALIGN_CHECK_EN defined, a request with latched addr[0]=1 SHALL complete with normal timing, perform no write, and respond with resp_rdata=0x0000 and resp_err=1.
REQ-031 Without MEM_ALIGN_CHECK_EN, addr[0] SHALL be ignored (0x0011 aliases 0x0010) and resp_err SHALL be tied to 0.

Verification
REQ-032 Reset; store 0xBEEF to 0x0010, then load 0x0010 -> resp_valid exactly 3 cycles after each acceptance, and the load returns 0xBEEF.
REQ-033 Load accepted; hold resp_ready low for 5 cycles -> resp_valid, resp_rdata and resp_err remain stable, req_ready=0 and busy=1 throughout.
REQ-034 With DEPTH_LOG2=8, store 0x1234 to 0x0202, then load 0x0002 -> 0x1234 returned (wrap-around).
REQ-035 With MEM_ALIGN_CHECK_EN defined, store 0xAAAA to 0x0011 then load 0x0010 -> store response has resp_err=1 and the load returns the prior value; without the macro, the load returns 0xAAAA.
REQ-036 Store 0x5555 to 0x0020 with rst pulsed during WAIT -> resp_valid never asserts for that store, and a later load of 0x0020 returns the pre-store value.
REQ-037 req_valid held high across the response handshake -> the second request is accepted one cycle after the handshake edge, and no request is lost or duplicated.
